// File: rtl/seven_seg_scan_ctrl.sv
// seven_seg_scan_ctrl
// Time-multiplexes NUM_DIGITS BCD digits onto one shared 7-segment decoder.
// Every digit slot lasts PRESCALE cycles. The first BLANK_CYCLES of each slot
// keep all selects off to suppress ghosting. All digits are snapshotted once
// per frame, so a frame never shows a mix of old and new digit values.
// Optional build macro: SEVEN_SEG_LZB_EN enables leading-zero blanking.
module seven_seg_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int PRESCALE     = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    output logic [3:0]              bcd_out,
    output logic                    dp_out,
    output logic [NUM_DIGITS-1:0]   digit_sel_n,
    output logic                    frame_done
);

    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CW = $clog2(PRESCALE);

    typedef enum logic [1:0] {
        IDLE,
        BLANK,
        SHOW
    } state_t;

    state_t                  state;
    logic [IW-1:0]           idx;
    logic [CW-1:0]           cnt;
    logic [4*NUM_DIGITS-1:0] snap_dig;
    logic [NUM_DIGITS-1:0]   snap_dp;

    logic [NUM_DIGITS-1:0]   lzb_mask;
    logic [3:0]              cur_digit;
    logic                    show_ok;
    logic                    last_digit;
    logic [IW-1:0]           nxt_idx;
    logic [3:0]              nxt_digit;
    logic                    nxt_dp;

    // Leading-zero mask, derived from the frame snapshot only
    always_comb begin
        lzb_mask = '0;
`ifdef SEVEN_SEG_LZB_EN
        begin
            logic suppress;
            suppress = 1'b1;
            for (int unsigned i = NUM_DIGITS - 1; i >= 1; i--) begin
                if (snap_dig[4*i +: 4] != 4'd0 || snap_dp[i])
                    suppress = 1'b0;
                lzb_mask[i] = suppress;
            end
        end
`endif
    end

    // Current/next digit selection and the visibility decision for this slot
    always_comb begin
        cur_digit  = snap_dig[{idx, 2'b00} +: 4];
        show_ok    = (cur_digit <= 4'd9) && !lzb_mask[idx];
        last_digit = (idx == IW'(NUM_DIGITS - 1));
        nxt_idx    = last_digit ? '0 : idx + 1'b1;
        // On wrap the decoder must already see the fresh snapshot's digit 0
        nxt_digit  = last_digit ? digits_in[3:0] : snap_dig[{nxt_idx, 2'b00} +: 4];
        nxt_dp     = last_digit ? dp_in[0] : snap_dp[nxt_idx];
    end

    // Scan FSM with registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            idx         <= '0;
            cnt         <= '0;
            snap_dig    <= '0;
            snap_dp     <= '0;
            bcd_out     <= '0;
            dp_out      <= 1'b0;
            digit_sel_n <= '1;
            frame_done  <= 1'b0;
        end else if (!en) begin
            state       <= IDLE;
            idx         <= '0;
            cnt         <= '0;
            digit_sel_n <= '1;
            frame_done  <= 1'b0;
        end else begin
            // Registered one cycle early so the pulse lines up with the final slot cycle
            frame_done <= (state != IDLE) && last_digit && (cnt == CW'(PRESCALE - 2));
            case (state)
                IDLE: begin
                    state       <= BLANK;
                    idx         <= '0;
                    cnt         <= '0;
                    snap_dig    <= digits_in;
                    snap_dp     <= dp_in;
                    bcd_out     <= digits_in[3:0];
                    dp_out      <= dp_in[0];
                    digit_sel_n <= '1;
                end
                BLANK: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(BLANK_CYCLES - 1)) begin
                        state       <= SHOW;
                        digit_sel_n <= show_ok ? ~(NUM_DIGITS'(1) << idx) : '1;
                    end
                end
                SHOW: begin
                    if (cnt == CW'(PRESCALE - 1)) begin
                        state       <= BLANK;
                        cnt         <= '0;
                        idx         <= nxt_idx;
                        digit_sel_n <= '1;
                        bcd_out     <= nxt_digit;
                        dp_out      <= nxt_dp;
                        if (last_digit) begin
                            snap_dig <= digits_in;
                            snap_dp  <= dp_in;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state       <= IDLE;
                    digit_sel_n <= '1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Testbench for seven_seg_scan_ctrl (NUM_DIGITS=4, PRESCALE=8, BLANK_CYCLES=2).
// Reference model tracks only "cycles since scan start" and the frame snapshot;
// digit index, slot phase and frame end are derived arithmetically from that.
module tb_seven_seg_scan_ctrl;

    localparam int N = 4;
    localparam int P = 8;
    localparam int B = 2;
    localparam int FRAME = N * P;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic [4*N-1:0] digits = '0;
    logic [N-1:0]  dps = '0;
    logic [3:0]    bcd_out;
    logic          dp_out;
    logic [N-1:0]  digit_sel_n;
    logic          frame_done;

    int total = 0;
    int bad = 0;

    // model state
    bit            active = 0;
    int            k = 0;
    logic [4*N-1:0] snap_d = '0;
    logic [N-1:0]  snap_p = '0;
    logic [N-1:0]  e_sel = '1;
    logic [3:0]    e_bcd = '0;
    logic          e_dp = 1'b0;
    logic          e_fd = 1'b0;

    seven_seg_scan_ctrl #(
        .NUM_DIGITS  (N),
        .PRESCALE    (P),
        .BLANK_CYCLES(B)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .digits_in  (digits),
        .dp_in      (dps),
        .bcd_out    (bcd_out),
        .dp_out     (dp_out),
        .digit_sel_n(digit_sel_n),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    function automatic int digit_of(logic [4*N-1:0] v, int i);
        return int'((v >> (4 * i)) & 16'hF);
    endfunction

    function automatic bit model_blank(int i);
`ifdef SEVEN_SEG_LZB_EN
        if (i == 0) return 1'b0;
        for (int j = N - 1; j >= i; j--)
            if (digit_of(snap_d, j) != 0 || snap_p[j]) return 1'b0;
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    // Advance one clock: update the model at the rising edge, return at the falling edge
    task automatic tick();
        int i, c;
        @(posedge clk);
        if (!rst_n) begin
            active = 0;
            e_bcd = '0;
            e_dp = 1'b0;
        end else if (en) begin
            if (!active) begin
                active = 1;
                k = 0;
                snap_d = digits;
                snap_p = dps;
            end else begin
                k++;
                if (k % FRAME == 0) begin
                    snap_d = digits;
                    snap_p = dps;
                end
            end
        end else begin
            active = 0;
        end
        if (active) begin
            i = (k / P) % N;
            c = k % P;
            e_bcd = 4'(digit_of(snap_d, i));
            e_dp = snap_p[i];
            e_sel = (c >= B && digit_of(snap_d, i) <= 9 && !model_blank(i)) ? ~(4'b1 << i) : 4'hF;
            e_fd = (i == N - 1) && (c == P - 1);
        end else begin
            e_sel = 4'hF;
            e_fd = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en = 1'b0;
        repeat (3) tick();
        total++;
        if ({digit_sel_n, bcd_out, dp_out, frame_done} !== {4'hF, 4'h0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL reset sel=%h/F bcd=%h/0 dp=%b/0 fd=%b/0", digit_sel_n, bcd_out, dp_out, frame_done);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_scan_basic();
        int pulses = 0;
        digits = 16'h4321;
        dps = '0;
        en = 1'b1;
        for (int n = 0; n < 70; n++) begin
            tick();
            pulses += int'(frame_done);
            total++;
            if ({digit_sel_n, bcd_out, dp_out, frame_done} !== {e_sel, e_bcd, e_dp, e_fd}) begin
                bad++;
                $display("FAIL scan k=%0d sel=%h/%h bcd=%h/%h dp=%b/%b fd=%b/%b", k,
                         digit_sel_n, e_sel, bcd_out, e_bcd, dp_out, e_dp, frame_done, e_fd);
            end
        end
        total++;
        if (pulses != 2) begin
            bad++;
            $display("FAIL frame_pulses got=%0d want=2", pulses);
        end
    endtask

    task automatic test_midframe_change();
        int guard = 0;
        while (!(active && (k / P) % N == 1 && k % P == 3) && guard < 100) begin
            tick();
            guard++;
        end
        total++;
        if (guard >= 100) begin
            bad++;
            $display("FAIL midframe_wait got=timeout want=digit1");
        end
        digits = 16'h9876;
        for (int n = 0; n < 50; n++) begin
            tick();
            total++;
            if ({digit_sel_n, bcd_out, dp_out, frame_done} !== {e_sel, e_bcd, e_dp, e_fd}) begin
                bad++;
                $display("FAIL midframe k=%0d sel=%h/%h bcd=%h/%h dp=%b/%b fd=%b/%b", k,
                         digit_sel_n, e_sel, bcd_out, e_bcd, dp_out, e_dp, frame_done, e_fd);
            end
        end
    endtask

    task automatic test_dp_and_invalid();
        dps = 4'b0100;
        digits = 16'hB321;
        for (int n = 0; n < 80; n++) begin
            tick();
            total++;
            if ({digit_sel_n, bcd_out, dp_out, frame_done} !== {e_sel, e_bcd, e_dp, e_fd}) begin
                bad++;
                $display("FAIL dp_invalid k=%0d sel=%h/%h bcd=%h/%h dp=%b/%b fd=%b/%b", k,
                         digit_sel_n, e_sel, bcd_out, e_bcd, dp_out, e_dp, frame_done, e_fd);
            end
        end
        dps = '0;
        digits = 16'h4321;
    endtask

    task automatic test_en_drop();
        int guard = 0;
        while (!(active && (k / P) % N == 2 && k % P == 4) && guard < 100) begin
            tick();
            guard++;
        end
        total++;
        if (guard >= 100) begin
            bad++;
            $display("FAIL en_drop_wait got=timeout want=digit2");
        end
        en = 1'b0;
        for (int n = 0; n < 60; n++) begin
            if (n == 20) en = 1'b1;
            tick();
            total++;
            if ({digit_sel_n, bcd_out, dp_out, frame_done} !== {e_sel, e_bcd, e_dp, e_fd}) begin
                bad++;
                $display("FAIL en_drop n=%0d sel=%h/%h bcd=%h/%h dp=%b/%b fd=%b/%b", n,
                         digit_sel_n, e_sel, bcd_out, e_bcd, dp_out, e_dp, frame_done, e_fd);
            end
        end
    endtask

    task automatic test_async_reset();
        int guard = 0;
        while (!(active && k % P == 5) && guard < 100) begin
            tick();
            guard++;
        end
        total++;
        if (guard >= 100 || digit_sel_n === 4'hF) begin
            bad++;
            $display("FAIL async_wait sel=%h want=one_low", digit_sel_n);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({digit_sel_n, bcd_out, dp_out, frame_done} !== {4'hF, 4'h0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL async_reset sel=%h/F bcd=%h/0 dp=%b/0 fd=%b/0", digit_sel_n, bcd_out, dp_out, frame_done);
        end
        active = 0;
        e_sel = 4'hF; e_bcd = '0; e_dp = 1'b0; e_fd = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int n = 0; n < 40; n++) begin
            tick();
            total++;
            if ({digit_sel_n, bcd_out, dp_out, frame_done} !== {e_sel, e_bcd, e_dp, e_fd}) begin
                bad++;
                $display("FAIL after_reset k=%0d sel=%h/%h bcd=%h/%h dp=%b/%b fd=%b/%b", k,
                         digit_sel_n, e_sel, bcd_out, e_bcd, dp_out, e_dp, frame_done, e_fd);
            end
        end
    endtask

    task automatic test_lzb_patterns();
        logic [4*N-1:0] pat [3];
        logic [N-1:0]   pdp [3];
        pat[0] = 16'h0050; pdp[0] = 4'b0000;
        pat[1] = 16'h0000; pdp[1] = 4'b0000;
        pat[2] = 16'h0050; pdp[2] = 4'b0100;
        for (int p = 0; p < 3; p++) begin
            digits = pat[p];
            dps = pdp[p];
            for (int n = 0; n < 2 * FRAME; n++) begin
                tick();
                total++;
                if ({digit_sel_n, bcd_out, dp_out, frame_done} !== {e_sel, e_bcd, e_dp, e_fd}) begin
                    bad++;
                    $display("FAIL lzb p=%0d k=%0d sel=%h/%h bcd=%h/%h dp=%b/%b fd=%b/%b", p, k,
                             digit_sel_n, e_sel, bcd_out, e_bcd, dp_out, e_dp, frame_done, e_fd);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                for (int i = 0; i < N; i++)
                    digits[4*i +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 11));
                dps = ($urandom_range(0, 3) == 0) ? 4'($urandom) : '0;
            end
            if ($urandom_range(0, 199) == 0) en = ~en;
            tick();
            total++;
            if ({digit_sel_n, bcd_out, dp_out, frame_done} !== {e_sel, e_bcd, e_dp, e_fd}) begin
                bad++;
                $display("FAIL random k=%0d sel=%h/%h bcd=%h/%h dp=%b/%b fd=%b/%b", k,
                         digit_sel_n, e_sel, bcd_out, e_bcd, dp_out, e_dp, frame_done, e_fd);
            end
        end
    endtask

    initial begin
        test_reset();
        test_scan_basic();
        test_midframe_change();
        test_dp_and_invalid();
        test_en_drop();
        test_async_reset();
        test_lzb_patterns();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
